// File: rtl/bp_nonsynth_host_arbiter_if.sv
// Bundle of the requester-side and host-side channels of the nonsynth host
// arbiter. Signal names keep the arbiter's point of view: the _i/_o suffix
// is the direction as seen by the arbiter.
//
// Handshake rule for every channel in this bundle: a beat transfers on a
// rising clock edge where valid and ready are both high. Valid must not
// wait for ready. Ready may depend combinationally on valid.
//
// Modports:
//   slave  - the arbiter itself
//   master - the environment (requesters plus host device)
//
// Signals:
//   req_cmd_header_i/data_i/v_i  per-requester commands, concatenated
//   req_cmd_ready_and_o          per-requester command ready (one-hot or 0)
//   req_resp_header_o/data_o     response payload, broadcast
//   req_resp_v_o                 per-requester response valid (one-hot or 0)
//   req_resp_ready_and_i         per-requester response ready
//   host_cmd_*                   single command channel to the host
//   host_resp_*                  single response channel from the host
interface bp_nonsynth_host_arbiter_if #(
  parameter int num_req_p    = 4,
  parameter int hdr_width_p  = 128,
  parameter int data_width_p = 64
);

  logic [num_req_p*hdr_width_p-1:0]  req_cmd_header_i;
  logic [num_req_p*data_width_p-1:0] req_cmd_data_i;
  logic [num_req_p-1:0]              req_cmd_v_i;
  logic [num_req_p-1:0]              req_cmd_ready_and_o;

  logic [hdr_width_p-1:0]            req_resp_header_o;
  logic [data_width_p-1:0]           req_resp_data_o;
  logic [num_req_p-1:0]              req_resp_v_o;
  logic [num_req_p-1:0]              req_resp_ready_and_i;

  logic [hdr_width_p-1:0]            host_cmd_header_o;
  logic [data_width_p-1:0]           host_cmd_data_o;
  logic                              host_cmd_v_o;
  logic                              host_cmd_ready_and_i;

  logic [hdr_width_p-1:0]            host_resp_header_i;
  logic [data_width_p-1:0]           host_resp_data_i;
  logic                              host_resp_v_i;
  logic                              host_resp_ready_and_o;

  modport slave (
    input  req_cmd_header_i, req_cmd_data_i, req_cmd_v_i,
    output req_cmd_ready_and_o,
    output req_resp_header_o, req_resp_data_o, req_resp_v_o,
    input  req_resp_ready_and_i,
    output host_cmd_header_o, host_cmd_data_o, host_cmd_v_o,
    input  host_cmd_ready_and_i,
    input  host_resp_header_i, host_resp_data_i, host_resp_v_i,
    output host_resp_ready_and_o
  );

  modport master (
    output req_cmd_header_i, req_cmd_data_i, req_cmd_v_i,
    input  req_cmd_ready_and_o,
    input  req_resp_header_o, req_resp_data_o, req_resp_v_o,
    output req_resp_ready_and_i,
    input  host_cmd_header_o, host_cmd_data_o, host_cmd_v_o,
    output host_cmd_ready_and_i,
    output host_resp_header_i, host_resp_data_i, host_resp_v_i,
    input  host_resp_ready_and_o
  );

endinterface

// File: rtl/bp_nonsynth_host_arbiter.sv
// Shares the single-beat nonsynth host device channel among num_req_p
// BedRock mem requesters.
//
// Commands are arbitrated round-robin into a one-entry registered command
// buffer that feeds the host. The ID of every accepted requester goes into an
// in-order FIFO; because the host answers in order with single beats, each
// host response belongs to the requester at the FIFO head and is routed there
// with zero latency.
//
// Ports:
//   clk_i          clock
//   reset_i        asynchronous, active-low reset
//   io             channel bundle (slave side), see the interface file
//   outstanding_o  commands accepted whose response has not yet returned
//                  (includes a command still sitting in the buffer)
//   error_o        sticky: a host response arrived with nothing outstanding
module bp_nonsynth_host_arbiter #(
  parameter int num_req_p     = 4,
  parameter int hdr_width_p   = 128,
  parameter int data_width_p  = 64,
  parameter int outstanding_p = 2
) (
  input  logic                               clk_i,
  input  logic                               reset_i,
  bp_nonsynth_host_arbiter_if.slave          io,
  output logic [$clog2(outstanding_p+1)-1:0] outstanding_o,
  output logic                               error_o
);

  localparam int id_w_lp  = $clog2(num_req_p);
  localparam int ptr_w_lp = (outstanding_p > 1) ? $clog2(outstanding_p) : 1;
  localparam int cnt_w_lp = $clog2(outstanding_p + 1);

  // Command buffer
  logic                    r_buf_v;
  logic [hdr_width_p-1:0]  r_buf_hdr;
  logic [data_width_p-1:0] r_buf_data;

  // Arbitration and ordering state
  logic [id_w_lp-1:0]      r_rr;
  logic [id_w_lp-1:0]      r_id_fifo [outstanding_p];
  logic [ptr_w_lp-1:0]     r_wptr;
  logic [ptr_w_lp-1:0]     r_rptr;
  // Doubles as the ID FIFO occupancy: every accepted command pushes one ID
  // and every host response pops one.
  logic [cnt_w_lp-1:0]     r_outstanding;
  logic                    r_error;

  logic                    w_drain;
  logic                    w_acc;
  logic                    w_found;
  logic [id_w_lp-1:0]      w_win;
  logic                    w_push;
  logic [num_req_p-1:0]    w_req_ready;
  logic                    w_nempty;
  logic [id_w_lp-1:0]      w_head;
  logic                    w_host_resp_ready;
  logic [num_req_p-1:0]    w_req_resp_v;
  logic                    w_pop;
  logic                    w_spurious;

  function automatic logic [ptr_w_lp-1:0] ptr_inc(input logic [ptr_w_lp-1:0] p);
    return (p == ptr_w_lp'(outstanding_p - 1)) ? '0 : p + 1'b1;
  endfunction

  // ---------------------------------------------------------------------------
  // Command side
  // ---------------------------------------------------------------------------
  assign w_drain = r_buf_v & io.host_cmd_ready_and_i;

  // The credit test uses the registered count, so a response popping in the
  // same cycle does not open a slot until the next cycle. reset_i gates the
  // term so no requester sees ready while reset is held.
  assign w_acc = reset_i & (~r_buf_v | w_drain)
               & (r_outstanding < cnt_w_lp'(outstanding_p));

  // First asserted valid at or after the rr pointer, wrapping.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int i = 0; i < num_req_p; i++) begin
      if (!w_found && io.req_cmd_v_i[(int'(r_rr) + i) % num_req_p]) begin
        w_found = 1'b1;
        w_win   = id_w_lp'((int'(r_rr) + i) % num_req_p);
      end
    end
  end

  // Winner's valid is known high, so a grant is a handshake.
  assign w_push = w_acc & w_found;

  always_comb begin
    w_req_ready = '0;
    if (w_push) w_req_ready[w_win] = 1'b1;
  end

  assign io.req_cmd_ready_and_o = w_req_ready;
  assign io.host_cmd_v_o        = r_buf_v;
  assign io.host_cmd_header_o   = r_buf_hdr;
  assign io.host_cmd_data_o     = r_buf_data;

  // Buffer payload needs no reset; r_buf_v qualifies it.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_buf_hdr  <= io.req_cmd_header_i[int'(w_win)*hdr_width_p +: hdr_width_p];
      r_buf_data <= io.req_cmd_data_i[int'(w_win)*data_width_p +: data_width_p];
    end
  end

  // ID storage; occupancy lives in r_outstanding.
  always_ff @(posedge clk_i) begin
    if (w_push) r_id_fifo[r_wptr] <= w_win;
  end

  // ---------------------------------------------------------------------------
  // Response side
  // ---------------------------------------------------------------------------
  assign w_nempty = (r_outstanding != '0);
  assign w_head   = r_id_fifo[r_rptr];

  always_comb begin
    w_req_resp_v = '0;
    if (io.host_resp_v_i && w_nempty) w_req_resp_v[w_head] = 1'b1;
  end

  assign w_host_resp_ready        = w_nempty & io.req_resp_ready_and_i[w_head];
  assign w_pop                    = io.host_resp_v_i & w_host_resp_ready;
  assign w_spurious               = io.host_resp_v_i & ~w_nempty;

  assign io.req_resp_v_o          = w_req_resp_v;
  assign io.req_resp_header_o     = io.host_resp_header_i;
  assign io.req_resp_data_o       = io.host_resp_data_i;
  assign io.host_resp_ready_and_o = w_host_resp_ready;

  assign outstanding_o = r_outstanding;
  assign error_o       = r_error;

  // ---------------------------------------------------------------------------
  // Control state
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_buf_v       <= 1'b0;
      r_rr          <= '0;
      r_wptr        <= '0;
      r_rptr        <= '0;
      r_outstanding <= '0;
      r_error       <= 1'b0;
    end else begin
      if (w_push)       r_buf_v <= 1'b1;
      else if (w_drain) r_buf_v <= 1'b0;

      if (w_push) begin
        r_rr   <= (w_win == id_w_lp'(num_req_p - 1)) ? '0 : w_win + 1'b1;
        r_wptr <= ptr_inc(r_wptr);
      end

      if (w_pop) r_rptr <= ptr_inc(r_rptr);

      case ({w_push, w_pop})
        2'b10:   r_outstanding <= r_outstanding + 1'b1;
        2'b01:   r_outstanding <= r_outstanding - 1'b1;
        default: r_outstanding <= r_outstanding;
      endcase

      if (w_spurious) r_error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bp_nonsynth_host_arbiter.sv
module tb_bp_nonsynth_host_arbiter;

  localparam int NR  = 4;
  localparam int HW  = 128;
  localparam int DW  = 64;
  localparam int OUT = 2;
  localparam int CW  = $clog2(OUT + 1);
  localparam int SD  = 32;

  localparam logic [HW-1:0] RMASK = 128'h5A5A_A5A5_0F0F_F0F0_3C3C_C3C3_9696_6969;
  localparam logic [DW-1:0] RADD  = 64'h0000_0000_0000_1000;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk_i   = 1'b0;
  logic reset_i = 1'b0;
  always #5 clk_i = ~clk_i;

  bp_nonsynth_host_arbiter_if #(.num_req_p(NR), .hdr_width_p(HW), .data_width_p(DW)) bus ();
  logic [CW-1:0] outstanding;
  logic          error;

  bp_nonsynth_host_arbiter #(
    .num_req_p(NR), .hdr_width_p(HW), .data_width_p(DW), .outstanding_p(OUT)
  ) dut (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .io            (bus),
    .outstanding_o (outstanding),
    .error_o       (error)
  );

  // ---------------------------------------------------------------------------
  // Bookkeeping
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_fail   = 0;

  function automatic void chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic void timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endfunction

  // Requester sources: main writes entries, the bfm consumes them.
  logic [HW-1:0] src_hdr [NR][SD];
  logic [DW-1:0] src_dat [NR][SD];
  int            src_wr  [NR];
  int            src_rd  [NR];

  // Host model controls
  int   resp_limit = 0;
  int   resp_sent  = 0;
  logic spur       = 1'b0;

  // Scoreboard
  logic [HW+DW-1:0]   exp_cmd_q  [$];
  logic [2+HW+DW-1:0] exp_resp_q [$];
  logic [HW+DW-1:0]   pend_q     [$];
  int                 grant_log  [$];

  task automatic push_cmd(input int k, input logic [HW-1:0] h, input logic [DW-1:0] d);
    src_hdr[k][src_wr[k] % SD] = h;
    src_dat[k][src_wr[k] % SD] = d;
    src_wr[k]++;
  endtask

  // ---------------------------------------------------------------------------
  // Requester/host driver plus monitor. Samples at negedge, drives at posedge+1.
  // ---------------------------------------------------------------------------
  initial begin : bfm
    logic [NR-1:0]      acc;
    logic               hcmd;
    logic               hresp;
    logic [HW+DW-1:0]   hcmd_val;
    logic [HW+DW-1:0]   ec;
    logic [2+HW+DW-1:0] er;
    logic [NR-1:0]      exp_oh;
    bus.req_cmd_v_i      = '0;
    bus.req_cmd_header_i = '0;
    bus.req_cmd_data_i   = '0;
    bus.host_resp_v_i    = 1'b0;
    bus.host_resp_header_i = '0;
    bus.host_resp_data_i   = '0;
    forever begin
      @(negedge clk_i);
      acc = '0; hcmd = 1'b0; hresp = 1'b0; hcmd_val = '0;
      if (reset_i) begin
        for (int k = 0; k < NR; k++) begin
          if (bus.req_cmd_v_i[k] && bus.req_cmd_ready_and_o[k]) begin
            acc[k] = 1'b1;
            exp_cmd_q.push_back({bus.req_cmd_header_i[k*HW +: HW], bus.req_cmd_data_i[k*DW +: DW]});
            exp_resp_q.push_back({2'(k), bus.req_cmd_header_i[k*HW +: HW] ^ RMASK,
                                  bus.req_cmd_data_i[k*DW +: DW] + RADD});
            grant_log.push_back(k);
          end
        end
        if (bus.req_cmd_ready_and_o != '0)
          chk("cmd_ready_onehot", 256'($countones(bus.req_cmd_ready_and_o)), 256'(1));
        if (bus.host_cmd_v_o && bus.host_cmd_ready_and_i) begin
          hcmd     = 1'b1;
          hcmd_val = {bus.host_cmd_header_o, bus.host_cmd_data_o};
          if (exp_cmd_q.size() == 0) timeout("host_cmd_unexpected");
          else begin
            ec = exp_cmd_q.pop_front();
            chk("host_cmd_payload", 256'(hcmd_val), 256'(ec));
          end
        end
        if (bus.host_resp_v_i && bus.host_resp_ready_and_o) hresp = 1'b1;
        if ((bus.req_resp_v_o & bus.req_resp_ready_and_i) != '0) begin
          if (exp_resp_q.size() == 0) timeout("resp_unexpected");
          else begin
            er     = exp_resp_q.pop_front();
            exp_oh = '0;
            exp_oh[er[2+HW+DW-1 -: 2]] = 1'b1;
            chk("resp_route",  256'(bus.req_resp_v_o), 256'(exp_oh));
            chk("resp_header", 256'(bus.req_resp_header_o), 256'(er[HW+DW-1 -: HW]));
            chk("resp_data",   256'(bus.req_resp_data_o), 256'(er[DW-1:0]));
          end
        end
      end
      @(posedge clk_i);
      #1;
      if (!reset_i) begin
        exp_cmd_q.delete();
        exp_resp_q.delete();
        pend_q.delete();
        grant_log.delete();
        for (int k = 0; k < NR; k++) src_rd[k] = src_wr[k];
        bus.req_cmd_v_i   = '0;
        bus.host_resp_v_i = 1'b0;
      end else begin
        for (int k = 0; k < NR; k++) if (acc[k]) src_rd[k]++;
        if (hresp) begin
          void'(pend_q.pop_front());
          resp_sent++;
        end
        if (hcmd) pend_q.push_back(hcmd_val);
        for (int k = 0; k < NR; k++) begin
          bus.req_cmd_v_i[k] = (src_rd[k] != src_wr[k]);
          bus.req_cmd_header_i[k*HW +: HW] = src_hdr[k][src_rd[k] % SD];
          bus.req_cmd_data_i[k*DW +: DW]   = src_dat[k][src_rd[k] % SD];
        end
        if (spur) begin
          bus.host_resp_v_i      = 1'b1;
          bus.host_resp_header_i = {HW{1'b1}};
          bus.host_resp_data_i   = {DW{1'b1}};
        end else if (pend_q.size() != 0 && resp_sent < resp_limit) begin
          bus.host_resp_v_i      = 1'b1;
          bus.host_resp_header_i = pend_q[0][HW+DW-1 -: HW] ^ RMASK;
          bus.host_resp_data_i   = pend_q[0][DW-1:0] + RADD;
        end else begin
          bus.host_resp_v_i = 1'b0;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Wait helpers (all bounded)
  // ---------------------------------------------------------------------------
  function automatic bit idle();
    bit ok;
    ok = (outstanding == '0) && !bus.host_cmd_v_o && exp_cmd_q.size() == 0
      && exp_resp_q.size() == 0 && pend_q.size() == 0;
    for (int k = 0; k < NR; k++) if (src_rd[k] != src_wr[k]) ok = 1'b0;
    return ok;
  endfunction

  task automatic wait_idle(input string name);
    bit seen = 1'b0;
    for (int n = 0; n < 300 && !seen; n++) begin @(negedge clk_i); seen = idle(); end
    if (!seen) timeout(name);
  endtask

  task automatic wait_accept(input int k);
    bit seen = 1'b0;
    for (int n = 0; n < 100 && !seen; n++) begin
      @(negedge clk_i);
      seen = bus.req_cmd_v_i[k] & bus.req_cmd_ready_and_o[k];
    end
    if (!seen) timeout("wait_accept");
  endtask

  task automatic wait_outs(input int v);
    bit seen = 1'b0;
    for (int n = 0; n < 100 && !seen; n++) begin @(negedge clk_i); seen = (outstanding == CW'(v)); end
    if (!seen) timeout("wait_outstanding");
  endtask

  task automatic wait_host_resp_fire();
    bit seen = 1'b0;
    for (int n = 0; n < 100 && !seen; n++) begin
      @(negedge clk_i);
      seen = bus.host_resp_v_i & bus.host_resp_ready_and_o;
    end
    if (!seen) timeout("wait_host_resp");
  endtask

  task automatic do_reset();
    @(posedge clk_i); #3;
    reset_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #3;
    reset_i = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  localparam logic [HW-1:0] HDR_A = 128'hAAAA_0000_0000_0000_0000_0000_0000_0002;

  initial begin : main
    bus.host_cmd_ready_and_i = 1'b1;
    bus.req_resp_ready_and_i = '1;

    // Reset state
    repeat (3) @(negedge clk_i);
    chk("rst_host_cmd_v",    256'(bus.host_cmd_v_o), 256'(0));
    chk("rst_cmd_ready",     256'(bus.req_cmd_ready_and_o), 256'(0));
    chk("rst_resp_v",        256'(bus.req_resp_v_o), 256'(0));
    chk("rst_host_resp_rdy", 256'(bus.host_resp_ready_and_o), 256'(0));
    chk("rst_outstanding",   256'(outstanding), 256'(0));
    chk("rst_error",         256'(error), 256'(0));
    @(posedge clk_i); #3;
    reset_i = 1'b1;

    // Single requester 2, one-cycle command latency, routed response
    resp_limit = resp_sent;
    push_cmd(2, HDR_A, 64'h41);
    wait_accept(2);
    @(negedge clk_i);
    chk("t1_host_cmd_v",    256'(bus.host_cmd_v_o), 256'(1));
    chk("t1_host_cmd_hdr",  256'(bus.host_cmd_header_o), 256'(HDR_A));
    chk("t1_host_cmd_data", 256'(bus.host_cmd_data_o), 256'(64'h41));
    chk("t1_outstanding",   256'(outstanding), 256'(1));
    resp_limit = resp_sent + 1;
    wait_host_resp_fire();
    chk("t1_resp_v", 256'(bus.req_resp_v_o), 256'(4'b0100));
    @(negedge clk_i);
    chk("t1_outstanding_0", 256'(outstanding), 256'(0));
    wait_idle("t1_idle");

    // Round-robin fairness from pointer 0
    do_reset();
    resp_limit = 1 << 30;
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < NR; k++)
        push_cmd(k, {64'hB000_0000_0000_0000 | 64'(k), 64'(r)}, 64'h100 + 64'(k * 8 + r));
    wait_idle("t2_idle");
    chk("t2_grant_count", 256'(grant_log.size()), 256'(8));
    for (int i = 0; i < 8; i++)
      if (i < grant_log.size()) chk("t2_grant_order", 256'(grant_log[i]), 256'(i % NR));

    // Credit limit: two issue, third waits until one response returns
    resp_limit = resp_sent;
    push_cmd(0, 128'hC0, 64'hC0);
    push_cmd(1, 128'hC1, 64'hC1);
    push_cmd(2, 128'hC2, 64'hC2);
    wait_outs(2);
    repeat (3) begin
      @(negedge clk_i);
      chk("t3_blocked_ready", 256'(bus.req_cmd_ready_and_o), 256'(0));
    end
    resp_limit = resp_sent + 1;
    wait_host_resp_fire();
    @(negedge clk_i);
    chk("t3_third_ready", 256'(bus.req_cmd_ready_and_o), 256'(4'b0100));
    resp_limit = 1 << 30;
    wait_idle("t3_idle");

    // Routing in issue order with back-pressure from requester 3
    resp_limit = resp_sent;
    push_cmd(3, 128'hD3, 64'hD3);
    wait_accept(3);
    push_cmd(1, 128'hD1, 64'hD1);
    wait_accept(1);
    repeat (3) @(negedge clk_i);
    @(posedge clk_i); #3;
    bus.req_resp_ready_and_i = 4'b0111;
    resp_limit = 1 << 30;
    repeat (2) @(negedge clk_i);
    repeat (3) begin
      @(negedge clk_i);
      chk("t4_host_resp_rdy_held", 256'(bus.host_resp_ready_and_o), 256'(0));
      chk("t4_resp_v_held",        256'(bus.req_resp_v_o), 256'(4'b1000));
    end
    @(posedge clk_i); #3;
    bus.req_resp_ready_and_i = '1;
    wait_idle("t4_idle");

    // Host stall: buffer holds, no new grants, then drain and reload together
    @(posedge clk_i); #3;
    bus.host_cmd_ready_and_i = 1'b0;
    push_cmd(0, 128'hE0, 64'hE0);
    wait_accept(0);
    push_cmd(0, 128'hE1, 64'hE1);
    repeat (5) begin
      @(negedge clk_i);
      chk("t5_stall_v",     256'(bus.host_cmd_v_o), 256'(1));
      chk("t5_stall_hdr",   256'(bus.host_cmd_header_o), 256'(128'hE0));
      chk("t5_stall_data",  256'(bus.host_cmd_data_o), 256'(64'hE0));
      chk("t5_stall_ready", 256'(bus.req_cmd_ready_and_o), 256'(0));
    end
    @(posedge clk_i); #3;
    bus.host_cmd_ready_and_i = 1'b1;
    @(negedge clk_i);
    chk("t5_reload_ready", 256'(bus.req_cmd_ready_and_o), 256'(4'b0001));
    @(negedge clk_i);
    chk("t5_reload_v",   256'(bus.host_cmd_v_o), 256'(1));
    chk("t5_reload_hdr", 256'(bus.host_cmd_header_o), 256'(128'hE1));
    wait_idle("t5_idle");

    // Spurious host response sets the sticky error
    spur = 1'b1;
    @(negedge clk_i);
    @(negedge clk_i);
    chk("t6_spur_ready", 256'(bus.host_resp_ready_and_o), 256'(0));
    chk("t6_spur_resp_v", 256'(bus.req_resp_v_o), 256'(0));
    spur = 1'b0;
    @(negedge clk_i);
    chk("t6_error_set", 256'(error), 256'(1));
    repeat (3) @(negedge clk_i);
    chk("t6_error_sticky", 256'(error), 256'(1));

    // Asynchronous reset mid-flight
    resp_limit = resp_sent;
    push_cmd(0, 128'hF0, 64'hF0);
    push_cmd(1, 128'hF1, 64'hF1);
    wait_outs(2);
    #2;
    reset_i = 1'b0;
    #1;
    chk("t7_host_cmd_v",  256'(bus.host_cmd_v_o), 256'(0));
    chk("t7_cmd_ready",   256'(bus.req_cmd_ready_and_o), 256'(0));
    chk("t7_resp_v",      256'(bus.req_resp_v_o), 256'(0));
    chk("t7_host_resp_rdy", 256'(bus.host_resp_ready_and_o), 256'(0));
    chk("t7_outstanding", 256'(outstanding), 256'(0));
    chk("t7_error",       256'(error), 256'(0));
    repeat (2) @(posedge clk_i);
    #3;
    reset_i = 1'b1;
    resp_limit = 1 << 30;
    repeat (3) begin
      @(negedge clk_i);
      chk("t7_no_route", 256'(bus.req_resp_v_o), 256'(0));
    end
    push_cmd(1, 128'h77, 64'h77);
    wait_idle("t7_idle");
    chk("final_resp_q_empty", 256'(exp_resp_q.size()), 256'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
